// File: rtl/uart_tx_framer.sv
// UART transmit framer: latches a word on a valid/busy handshake and shifts out
// start, LSB-first data, optional parity and one or two stop bits on baud strobes.
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    input  logic                  i_stop2,
    input  logic                  i_baud_en,
    output logic                  o_tx_out,
    output logic                  o_busy
);

    // state    | meaning (next bit to drive)
    // S_IDLE   | line high, waiting for a request
    // S_START  | start bit
    // S_DATA   | data bit r_bit_cnt
    // S_PARITY | parity bit
    // S_STOP   | stop bit(s)
    // S_END    | close the final stop-bit period, release busy
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_END
    } state_t;

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_tx_out;
    logic                  r_busy;

    assign o_tx_out = r_tx_out;
    assign o_busy   = r_busy;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_tx_out <= 1'b1;
            if (i_data_valid) begin
                // parity of the accepted word is fixed here so live inputs never leak in
                r_shift    <= i_p_data;
                r_par_en   <= i_par_en;
                r_par_bit  <= (^i_p_data) ^ i_par_typ;
                r_stop2    <= i_stop2;
                r_stop_cnt <= 1'b0;
                r_busy     <= 1'b1;
                r_state    <= S_START;
            end
        end else if (i_baud_en) begin
            case (r_state)
                S_START: begin
                    r_tx_out  <= 1'b0;
                    r_bit_cnt <= '0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    r_tx_out  <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LAST_BIT)
                        r_state <= r_par_en ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    r_tx_out <= r_par_bit;
                    r_state  <= S_STOP;
                end
                S_STOP: begin
                    r_tx_out <= 1'b1;
                    if (r_stop2 && !r_stop_cnt)
                        r_stop_cnt <= 1'b1;
                    else
                        r_state <= S_END;
                end
                S_END: begin
                    r_tx_out <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_tx_out <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
